dac_i2s_fifo: RTL and testbench
===============================

// Module: dac_i2s_fifo
// PURPOSE
//   Parametrised serial-audio DAC controller for stereo codecs.
//   Accepts stereo samples through a valid/ready port into a small FIFO.
//   Generates mclk/sclk/lrck from clk and shifts one stereo frame per lrck period onto sdti.
//   Sits between the sound-generating logic and the external DAC pins.
// PARAMETERS
//   SW      16  sample width in bits, 1..24
//   SLOT    32  sclk periods per channel slot; SLOT >= SW (SLOT >= SW+1 with DAC_I2S_EN)
//   MDIV     4  mclk period in clk cycles; even, >= 2
//   BDIV    16  sclk period in clk cycles; even, >= 2
//   DEPTH    4  FIFO depth in stereo samples; power of two, >= 2
//   Derived: FRAME = 2*SLOT*BDIV clk cycles per lrck period; LW = clog2(DEPTH+1)
// PORTS
//   clk       in   1     system clock
//   rst       in   1     asynchronous reset, active high
//   in_valid  in   1     sample pair valid
//   in_ready  out  1     FIFO can accept (= !full)
//   in_l      in   SW    left sample, two's complement
//   in_r      in   SW    right sample, two's complement
//   level     out  LW    FIFO occupancy, 0..DEPTH
//   frame     out  1     one-cycle pulse at frame load (t == FRAME-1)
//   underrun  out  1     one-cycle pulse: load found FIFO empty
//   mclk      out  1     master clock to DAC
//   sclk      out  1     bit clock to DAC
//   lrck      out  1     word clock; 0 = left slot, 1 = right slot
//   sdti      out  1     serial data, MSB first
// BEHAVIOUR
//   - Reset (async, rst=1):
//     - counter t = 0; mclk, sclk, lrck, sdti, frame, underrun = 0.
//     - FIFO empty: level = 0, in_ready = 1.
//     - Reset mid-frame aborts the frame; the FIFO contents are discarded.
//   - Timing counter t: free-running, 0..FRAME-1, wraps to 0.
//     - mclk = (t mod MDIV) >= MDIV/2.
//     - sclk = (t mod BDIV) >= BDIV/2.
//     - lrck = (t >= SLOT*BDIV).
//     - All outputs are driven from flops; glitch-free.
//   - FIFO push: on a clk edge with in_valid && in_ready, store {in_l, in_r}.
//     - in_ready depends only on the full state, never on a same-cycle pop.
//     - A push to a full FIFO cannot occur.
//   - Load, at t == FRAME-1:
//     - frame = 1 for that cycle.
//     - If FIFO not empty: pop the head, level-1 (+1 if a push occurs in the same cycle).
//     - Push and pop in the same cycle are both performed.
//     - Load the 2*SLOT-bit shift register with the frame word (see CONFIGURATION).
//     - If FIFO empty: load all zeros; underrun = 1 on the following cycle only.
//   - Shift: when (t mod BDIV) == BDIV-1 and not a load cycle, shift left one bit, fill 0.
//     - sdti = shift register MSB. Data changes on sclk falling edge; stable at DAC sample (rising) edge.
//   - Latency: a sample pushed into an empty FIFO before cycle FRAME-1 appears on sdti starting at t = 0 of the next frame.
//   - Sample bits are passed unmodified; no rounding or saturation.
// CONFIGURATION
//   - DAC_I2S_EN undefined (right-justified, legacy codec format):
//     - Frame word = {(SLOT-SW)'0, L, (SLOT-SW)'0, R}.
//     - The LSB of each channel occupies the last bit of its slot.
//   - DAC_I2S_EN defined (Philips I2S):
//     - Frame word = {1'b0, L, (SLOT-SW-1)'0, 1'b0, R, (SLOT-SW-1)'0}.
//     - The MSB of each channel appears one sclk period after the lrck edge.
//     - Elaboration fails if SLOT < SW+1.
// TESTING (defaults: FRAME = 1024)
//   - Release reset, no push:
//     - mclk period 4, sclk period 16, lrck high for t = 512..1023.
//     - underrun pulses at t = 0 of each frame; sdti stays 0.
//   - Push L=16'hA5C3, R=16'h0001 at t=100:
//     - level = 1, then 0 after t = 1023.
//     - Next frame: sdti = 0 for left bits 0..15; bits 16..31 = A5C3 MSB first.
//     - Right slot: only bit 63 = 1.
//   - Push 5 pairs back-to-back into an empty FIFO:
//     - First 4 accepted, level = 4, in_ready = 0; 5th held off.
//     - One pop per frame; in_ready returns to 1 after the next load.
//   - Push with in_valid at t = 1023 while level = 1:
//     - Pop and push both occur; level stays 1.
//   - Assert rst at t = 300 with level = 2:
//     - All outputs 0 and level = 0 without a clk edge.
//     - After release, t restarts at 0.
//   - DAC_I2S_EN, L = 16'h8000, R = 16'hFFFF:
//     - sdti = 1 at left bit 1 only.
//     - sdti = 1 at right bits 33..48; 0 elsewhere.

Source files
------------

// File: rtl/dac_i2s_fifo_if.sv
// rtl/dac_i2s_fifo_if.sv - stereo sample valid/ready bundle feeding dac_i2s_fifo
interface dac_i2s_fifo_if #(
    parameter int SW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_l;
    logic [SW-1:0] in_r;

    modport master (output in_valid, output in_l, output in_r, input in_ready);
    modport slave  (input in_valid, input in_l, input in_r, output in_ready);
endinterface

// File: rtl/dac_i2s_fifo.sv
// rtl/dac_i2s_fifo.sv - stereo DAC serialiser with sample FIFO; DAC_I2S_EN selects Philips I2S framing
module dac_i2s_fifo #(
    parameter int SW    = 16,
    parameter int SLOT  = 32,
    parameter int MDIV  = 4,
    parameter int BDIV  = 16,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    dac_i2s_fifo_if.slave bus,
    output logic [LW-1:0] level,
    output logic          frame,
    output logic          underrun,
    output logic          mclk,
    output logic          sclk,
    output logic          lrck,
    output logic          sdti
);
    localparam int FRAME = 2 * SLOT * BDIV;
    localparam int TW    = $clog2(FRAME);
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = 2 * SLOT;
    localparam logic [TW-1:0] T_LAST  = TW'(FRAME - 1);
    localparam logic [TW-1:0] T_RIGHT = TW'(SLOT * BDIV);

`ifdef DAC_I2S_EN
    if (SLOT < SW + 1) begin : g_slot_check
        $error("dac_i2s_fifo: I2S framing needs SLOT >= SW+1");
    end
`endif

    logic [TW-1:0]   t;
    logic [TW-1:0]   t_next;
    logic [2*SW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [FW-1:0]   sr;
    logic [FW-1:0]   frame_word;
    logic            load;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            bit_end;

    assign load         = (t == T_LAST);
    assign t_next       = load ? '0 : t + TW'(1);
    assign bit_end      = (int'(t) % BDIV) == (BDIV - 1);
    assign empty        = (level == '0);
    assign full         = (level == LW'(DEPTH));
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = load && !empty;
    assign sdti         = sr[FW-1];

    // Place the FIFO head into its slot positions; an empty FIFO yields silence
    always_comb begin
        frame_word = '0;
        if (!empty) begin
`ifdef DAC_I2S_EN
            frame_word[FW-2 -: SW]   = mem[rd_ptr][2*SW-1 -: SW];
            frame_word[SLOT-2 -: SW] = mem[rd_ptr][SW-1:0];
`else
            frame_word[SLOT +: SW]   = mem[rd_ptr][2*SW-1 -: SW];
            frame_word[0 +: SW]      = mem[rd_ptr][SW-1:0];
`endif
        end
    end

    // Frame counter and clock outputs, registered from the next count so they track t exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t        <= '0;
            mclk     <= 1'b0;
            sclk     <= 1'b0;
            lrck     <= 1'b0;
            frame    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            t        <= t_next;
            mclk     <= (int'(t_next) % MDIV) >= (MDIV / 2);
            sclk     <= (int'(t_next) % BDIV) >= (BDIV / 2);
            lrck     <= (t_next >= T_RIGHT);
            frame    <= (t_next == T_LAST);
            underrun <= load && empty;
        end
    end

    // Output shift register: load at frame end, advance on each sclk falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= frame_word;
        end else if (bit_end) begin
            sr <= {sr[FW-2:0], 1'b0};
        end
    end

    // Sample storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_l, bus.in_r};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_i2s_fifo.sv
// tb/tb_dac_i2s_fifo.sv - scoreboard bench for dac_i2s_fifo (default geometry, either framing)
module tb_dac_i2s_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] level;
    logic       frame, underrun, mclk, sclk, lrck, sdti;

    dac_i2s_fifo_if #(.SW(16)) bus ();

    dac_i2s_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .level    (level),
        .frame    (frame),
        .underrun (underrun),
        .mclk     (mclk),
        .sclk     (sclk),
        .lrck     (lrck),
        .sdti     (sdti)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] vl [6] = '{16'hA5C3, 16'h8000, 16'h1234, 16'hFFFF, 16'h0F0F, 16'h0001};
    logic [15:0] vr [6] = '{16'h0001, 16'hFFFF, 16'h5678, 16'h8000, 16'hF0F0, 16'h7FFF};
`ifdef DAC_I2S_EN
    logic [63:0] vw [6] = '{64'h52E18000_00008000, 64'h40000000_7FFF8000, 64'h091A0000_2B3C0000,
                            64'h7FFF8000_40000000, 64'h07878000_78780000, 64'h00008000_3FFF8000};
`else
    logic [63:0] vw [6] = '{64'h0000A5C3_00000001, 64'h00008000_0000FFFF, 64'h00001234_00005678,
                            64'h0000FFFF_00008000, 64'h00000F0F_0000F0F0, 64'h00000001_00007FFF};
`endif

    logic [63:0] exp_q [$];
    logic [63:0] cur_word;
    logic [63:0] cap;
    bit          load_empty;
    int          tb_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at tb_t=%0d: got %h expected %h", name, tb_t, act, exp);
        end
    endtask

    // Reference frame position, follows the DUT counter definition from reset
    always @(posedge clk or posedge rst) begin
        if (rst) tb_t <= 0;
        else     tb_t <= (tb_t == 1023) ? 0 : tb_t + 1;
    end

    // Monitor: pin timing every cycle, captured sdti frame against scoreboard at each load
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_word   = '0;
            load_empty = 1'b0;
        end else begin
            chk("mclk", 64'(mclk), 64'((tb_t % 4) >= 2));
            chk("sclk", 64'(sclk), 64'((tb_t % 16) >= 8));
            chk("lrck", 64'(lrck), 64'(tb_t >= 512));
            chk("frame", 64'(frame), 64'(tb_t == 1023));
            chk("underrun", 64'(underrun), 64'(tb_t == 0 && load_empty));
            chk("level", 64'(level), 64'(exp_q.size()));
            chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 4));
            if (tb_t == 0) load_empty = 1'b0;
            if ((tb_t % 16) == 8) cap[63 - tb_t / 16] = sdti;
            if (tb_t == 1023) begin
                chk("sdti_frame", cap, cur_word);
                if (exp_q.size() > 0) begin
                    cur_word   = exp_q.pop_front();
                    load_empty = 1'b0;
                end else begin
                    cur_word   = '0;
                    load_empty = 1'b1;
                end
            end
        end
    end

    task automatic wait_t(input int target);
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (tb_t == target) return;
        end
        chk("wait_t_timeout", 64'(tb_t), 64'(target));
    endtask

    task automatic push(input int idx, input int max_wait, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_l     = vl[idx];
        bus.in_r     = vr[idx];
        for (int i = 0; i < max_wait; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                exp_q.push_back(vw[idx]);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_mclk"}, 64'(mclk), 64'd0);
        chk({tag, "_sclk"}, 64'(sclk), 64'd0);
        chk({tag, "_lrck"}, 64'(lrck), 64'd0);
        chk({tag, "_sdti"}, 64'(sdti), 64'd0);
        chk({tag, "_frame"}, 64'(frame), 64'd0);
        chk({tag, "_underrun"}, 64'(underrun), 64'd0);
        chk({tag, "_level"}, 64'(level), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_l     = '0;
        bus.in_r     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst_init");
        @(negedge clk);
        #2 rst = 1'b0;

        // idle frame, then one pair at t=100
        wait_t(1023);
        wait_t(99);
        push(0, 4, ok);
        chk("push_a5c3_ok", 64'(ok), 64'd1);

        // burst of five into an empty FIFO
        wait_t(1023);
        wait_t(200);
        for (int i = 1; i <= 4; i++) begin
            push(i, 4, ok);
            chk("burst_ok", 64'(ok), 64'd1);
        end
        @(negedge clk);
        chk("burst_level", 64'(level), 64'd4);
        chk("burst_ready", 64'(bus.in_ready), 64'd0);
        push(5, 3, ok);
        chk("fifth_held_off", 64'(ok), 64'd0);
        push(5, 1100, ok);
        chk("fifth_accepted", 64'(ok), 64'd1);
        chk("fifth_accept_t", 64'(tb_t), 64'd1);

        // coincident push and pop at the load with one entry queued
        for (int i = 0; i < 6000 && exp_q.size() != 1; i++) @(negedge clk);
        chk("drain_to_one", 64'(exp_q.size()), 64'd1);
        wait_t(1022);
        push(3, 2, ok);
        chk("coincident_ok", 64'(ok), 64'd1);
        @(negedge clk);
        chk("coincident_level", 64'(level), 64'd1);

        // mid-frame reset with two entries held
        push(4, 4, ok);
        chk("pre_reset_push", 64'(ok), 64'd1);
        wait_t(300);
        chk("pre_reset_level", 64'(level), 64'd2);
        #2 rst = 1'b1;
        #1;
        reset_checks("rst_mid");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // post-reset traffic, including the I2S boundary vector
        wait_t(99);
        push(1, 4, ok);
        chk("post_reset_push1", 64'(ok), 64'd1);
        wait_t(499);
        push(5, 4, ok);
        chk("post_reset_push2", 64'(ok), 64'd1);
        wait_t(1023);
        wait_t(1023);
        wait_t(1023);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
